// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with in-order request tracking and output buffer
//
// Purpose:
//   Owns the fetch PC, issues in-order word reads to instruction memory and
//   buffers the returned words, tagged with their PC, towards decode. A
//   redirect reloads the PC and squashes every younger fetch, whether it is
//   still in flight or already buffered.
//
// Ports:
//   clock, reset_n                 clock, asynchronous active-low reset
//   redirect, redirect_pc          PC reload request and target
//   imem_req_valid/ready/addr      read request channel (valid/ready)
//   imem_rsp_valid/data            read response channel (in order, never stalled)
//   inst_valid/ready/data/pc       instruction channel to decode (valid/ready)

module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_INC   = 4,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t            DEPTH_CNT = cnt_t'(DEPTH);
  localparam ptr_t            PTR_LAST  = ptr_t'(DEPTH - 1);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(PC_INC);

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == PTR_LAST) begin
      return '0;
    end
    return p + ptr_t'(1);
  endfunction

  // Fetch PC and bookkeeping counters
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  cnt_t            outstanding_q, outstanding_d;
  cnt_t            stale_q, stale_d;

  // PCs of in-flight requests, oldest at pend_rd_q
  logic [XLEN-1:0] pend_q [DEPTH];
  ptr_t            pend_wr_q, pend_wr_d;
  ptr_t            pend_rd_q, pend_rd_d;

  // Output buffer of {pc, data}
  logic [XLEN-1:0] fifo_pc_q   [DEPTH];
  logic [31:0]     fifo_data_q [DEPTH];
  ptr_t            fifo_wr_q, fifo_wr_d;
  ptr_t            fifo_rd_q, fifo_rd_d;
  cnt_t            fifo_cnt_q, fifo_cnt_d;

  logic [CW:0] credit_used;
  logic        req_fire;
  logic        rsp_fire;
  logic        rsp_keep;
  logic        inst_pop;

  // A request is only issued when every possible answer already has a home
  // in the output buffer; the pre-edge counts are used, so a pop in the same
  // cycle does not free a slot until the next one.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
  assign imem_req_valid = reset_n & ~redirect & (credit_used < {1'b0, DEPTH_CNT});
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid & imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire = imem_rsp_valid & (outstanding_q != '0);
  // Responses are dropped while older squashed requests drain, and also when
  // they coincide with a redirect.
  assign rsp_keep = rsp_fire & (stale_q == '0) & ~redirect;

  assign inst_valid = (fifo_cnt_q != '0);
  assign inst_pc    = fifo_pc_q[fifo_rd_q];
  assign inst_data  = fifo_data_q[fifo_rd_q];
  assign inst_pop   = inst_valid & inst_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(rsp_fire);
    stale_d       = stale_q;
    pend_wr_d     = pend_wr_q;
    pend_rd_d     = pend_rd_q;
    fifo_wr_d     = fifo_wr_q;
    fifo_rd_d     = fifo_rd_q;
    fifo_cnt_d    = fifo_cnt_q + cnt_t'(rsp_keep) - cnt_t'(inst_pop);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
      pend_wr_d  = ptr_inc(pend_wr_q);
    end
    if (rsp_fire) begin
      pend_rd_d = ptr_inc(pend_rd_q);
      if (stale_q != '0) begin
        stale_d = stale_q - cnt_t'(1);
      end
    end
    if (rsp_keep) begin
      fifo_wr_d = ptr_inc(fifo_wr_q);
    end
    if (inst_pop) begin
      fifo_rd_d = ptr_inc(fifo_rd_q);
    end

    // Everything still in flight after this edge belongs to the old path.
    // Any decode handshake this cycle has already completed, so the buffer
    // can simply be emptied.
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      stale_d    = outstanding_q - cnt_t'(rsp_fire);
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      fifo_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      stale_q       <= '0;
      pend_wr_q     <= '0;
      pend_rd_q     <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      fifo_cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pend_q[i]      <= '0;
        fifo_pc_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      pend_wr_q     <= pend_wr_d;
      pend_rd_q     <= pend_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_cnt_q    <= fifo_cnt_d;
      if (req_fire) begin
        pend_q[pend_wr_q] <= fetch_pc_q;
      end
      if (rsp_keep) begin
        fifo_pc_q[fifo_wr_q]   <= pend_q[pend_rd_q];
        fifo_data_q[fifo_wr_q] <= imem_rsp_data;
      end
    end
  end

  rsp_needs_outstanding: assert property (
    @(posedge clock) disable iff (!reset_n) imem_rsp_valid |-> (outstanding_q != '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit

module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } inst_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          req_count = 0;
  int          mem_lat = 1;
  logic [31:0] exp_req_pc = 32'h0;
  inst_t       exp_q[$];

  logic        mv [3];
  logic [31:0] ma [3];

  always #5 clock = ~clock;

  fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0),
    .PC_INC  (4),
    .DEPTH   (2)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %h expected none", name, act);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] data);
    inst_t e;
    e.pc   = pc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int lat);
    reset_n        = 1'b0;
    redirect       = 1'b0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    mem_lat        = lat;
    exp_req_pc     = 32'h0;
    exp_q.delete();
    tick();
    tick();
    req_count = 0;
    reset_n   = 1'b1;
  endtask

  // Consume buffered expectations with inst_ready high, then drop inst_ready.
  task automatic drain(input string name, input int budget);
    inst_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) fail_now(name, 32'(exp_q.size()));
    #1;
    inst_ready = 1'b0;
  endtask

  // Memory: fixed latency of 1..3 cycles, answers in order.
  initial begin : mem_model
    for (int i = 0; i < 3; i++) begin
      mv[i] = 1'b0;
      ma[i] = 32'h0;
    end
    forever begin
      @(posedge clock);
      if (!reset_n) begin
        for (int i = 0; i < 3; i++) mv[i] = 1'b0;
      end else begin
        mv[2] = mv[1]; ma[2] = ma[1];
        mv[1] = mv[0]; ma[1] = ma[0];
        mv[0] = imem_req_valid & imem_req_ready;
        ma[0] = imem_req_addr;
      end
      #1;
      imem_rsp_valid = mv[mem_lat-1];
      imem_rsp_data  = mv[mem_lat-1] ? mdata(ma[mem_lat-1]) : 32'h0;
    end
  end

  // Request monitor: every accepted address must follow the bench's PC model.
  initial begin : req_mon
    forever begin
      @(negedge clock);
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_req_pc);
        exp_req_pc = exp_req_pc + 32'd4;
        req_count++;
      end
    end
  end

  // Instruction monitor: pops the scoreboard on every decode handshake.
  initial begin : inst_mon
    inst_t e;
    forever begin
      @(negedge clock);
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("inst_unexpected_pc", inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e.pc);
          check("inst_data", inst_data, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset_n        = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);

    // 1: sequential stream, latency 1, decode always ready
    tick();
    reset_n = 1'b1;
    push(32'h0,  32'hFFFF_0000);
    push(32'h4,  32'hFFFB_0004);
    push(32'h8,  32'hFFF7_0008);
    push(32'hC,  32'hFFF3_000C);
    push(32'h10, 32'hFFEF_0010);
    drain("t1_drain_timeout", 40);

    // 2: decode stalled, credit limit holds requests at DEPTH
    tick();
    do_reset(1);
    push(32'h0, 32'hFFFF_0000);
    push(32'h4, 32'hFFFB_0004);
    push(32'h8, 32'hFFF7_0008);
    repeat (6) tick();
    @(negedge clock);
    check("t2_req_count", 32'(req_count), 32'd2);
    check("t2_inst_valid", 32'(inst_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clock);
      check("t2_req_valid_low", 32'(imem_req_valid), 32'h0);
      check("t2_hold_pc", inst_pc, 32'h0);
      check("t2_hold_data", inst_data, 32'hFFFF_0000);
    end
    tick();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    repeat (4) tick();
    @(negedge clock);
    check("t2_req_count_after_pop", 32'(req_count), 32'd3);
    check("t2_head_pc", inst_pc, 32'h4);
    check("t2_req_valid_full", 32'(imem_req_valid), 32'h0);
    tick();
    drain("t2_drain_timeout", 20);

    // 3: request stalled by memory at 0x40
    tick();
    do_reset(1);
    imem_req_ready = 1'b0;
    redirect       = 1'b1;
    redirect_pc    = 32'h40;
    exp_req_pc     = 32'h40;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t3_stall_valid", 32'(imem_req_valid), 32'h1);
      check("t3_stall_addr", imem_req_addr, 32'h40);
      tick();
    end
    imem_req_ready = 1'b1;
    push(32'h40, 32'hFFBF_0040);
    inst_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    @(negedge clock);
    check("t3_next_addr", imem_req_addr, 32'h44);
    check("t3_req_count", 32'(req_count), 32'd1);
    tick();
    drain("t3_drain_timeout", 20);

    // 4: redirect with two requests in flight (latency 3)
    tick();
    do_reset(3);
    redirect    = 1'b1;
    redirect_pc = 32'h10;
    exp_req_pc  = 32'h10;
    inst_ready  = 1'b1;
    push(32'h100, 32'hFEFF_0100);
    push(32'h104, 32'hFEFB_0104);
    tick();
    redirect = 1'b0;
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    exp_req_pc  = 32'h100;
    @(negedge clock);
    check("t4_req_valid_redirect", 32'(imem_req_valid), 32'h0);
    check("t4_in_flight", 32'(req_count), 32'd2);
    tick();
    redirect = 1'b0;
    @(negedge clock);
    check("t4_inst_valid_after", 32'(inst_valid), 32'h0);
    tick();
    drain("t4_drain_timeout", 30);

    // 5: redirect coincident with a response and a decode handshake, wrap at 2^32
    tick();
    do_reset(1);
    push(32'h0,         32'hFFFF_0000);
    push(32'hFFFF_FFFC, 32'h0003_FFFC);
    push(32'h0,         32'hFFFF_0000);
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    exp_req_pc  = 32'hFFFF_FFFC;
    inst_ready  = 1'b1;
    @(negedge clock);
    check("t5_rsp_coincident", 32'(imem_rsp_valid), 32'h1);
    check("t5_head_pc", inst_pc, 32'h0);
    tick();
    redirect = 1'b0;
    @(negedge clock);
    check("t5_inst_valid_cleared", 32'(inst_valid), 32'h0);
    tick();
    drain("t5_drain_timeout", 30);

    // 6: reset mid-stream
    repeat (4) tick();
    @(negedge clock);
    check("t6_pre_reset_valid", 32'(inst_valid), 32'h1);
    tick();
    reset_n    = 1'b0;
    exp_req_pc = 32'h0;
    #1;
    check("t6_rst_inst_valid", 32'(inst_valid), 32'h0);
    check("t6_rst_req_valid", 32'(imem_req_valid), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    push(32'h0, 32'hFFFF_0000);
    @(negedge clock);
    check("t6_first_addr", imem_req_addr, 32'h0);
    check("t6_first_valid", 32'(imem_req_valid), 32'h1);
    tick();
    drain("t6_drain_timeout", 20);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
